// File: rtl/scanchain_target.sv
// Scan-chain frame receiver: synchronizes an external scan port into clk, shifts
// ADDR_BITS+PAYLOAD_BITS frames and commits them to a valid/ready output. Optional debug outputs: SCANCHAIN_TARGET_DEBUG_EN.
module scanchain_target #(
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned PAYLOAD_BITS = 160,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    scan_reset,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_BITS-1:0]    out_addr,
  output logic [PAYLOAD_BITS-1:0] out_payload,
  output logic                    frame_error,
  output logic                    overrun
`ifdef SCANCHAIN_TARGET_DEBUG_EN
  ,
  output logic [7:0]              debug_bit_count,
  output logic [7:0]              debug_frame_count
`endif
);

  localparam int unsigned FRAME = ADDR_BITS + PAYLOAD_BITS;
  localparam int unsigned CNT_W = $clog2(FRAME + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [FRAME-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               commit, err_d, ovr_d, valid_d;
  logic               sclk_d;
  logic [3:0]         sync_q [SYNC_STAGES];
  logic               s_clk, s_en, s_in, s_rst, s_rise;

  // Bit order per stage: {scan_reset, scan_en, scan_in, scan_clk}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sclk_d <= 1'b0;
    end else begin
      sync_q[0] <= {scan_reset, scan_en, scan_in, scan_clk};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_d <= s_clk;
    end
  end

  assign s_clk  = sync_q[SYNC_STAGES-1][0];
  assign s_in   = sync_q[SYNC_STAGES-1][1];
  assign s_en   = sync_q[SYNC_STAGES-1][2];
  assign s_rst  = sync_q[SYNC_STAGES-1][3];
  assign s_rise = s_clk & ~sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame end is evaluated before shifting, so a rise coincident with scan_en falling is dropped
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    if (s_rst) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_en) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (!s_en) begin
            state_d = IDLE;
            if (cnt_q == CNT_W'(FRAME)) begin
              if (out_valid) ovr_d  = 1'b1;
              else           commit = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (s_rise) begin
            sr_d = {sr_q[FRAME-2:0], s_in};
            if (cnt_q != CNT_W'(FRAME + 1)) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = out_valid;
    if (commit)                      valid_d = 1'b1;
    else if (out_valid && out_ready) valid_d = 1'b0;
  end

  // Held frame only changes on commit, which requires out_valid low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_payload <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid   <= valid_d;
      frame_error <= err_d;
      overrun     <= ovr_d;
      if (commit) begin
        out_addr    <= sr_q[FRAME-1 -: ADDR_BITS];
        out_payload <= sr_q[PAYLOAD_BITS-1:0];
      end
    end
  end

`ifdef SCANCHAIN_TARGET_DEBUG_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       frame_cnt_q <= '0;
    else if (commit) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign debug_bit_count   = 8'(cnt_q);
  assign debug_frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_scanchain_target.sv
// Self-checking bench for scanchain_target: random frames against a frame-level outcome model.
module tb_scanchain_target;

  localparam int unsigned AB    = 12;
  localparam int unsigned PB    = 160;
  localparam int unsigned FRAME = AB + PB;

  logic          clk = 1'b0;
  logic          reset, scan_clk, scan_en, scan_in, scan_reset, out_ready;
  logic          out_valid, frame_error, overrun;
  logic [AB-1:0] out_addr;
  logic [PB-1:0] out_payload;
`ifdef SCANCHAIN_TARGET_DEBUG_EN
  logic [7:0]    debug_bit_count, debug_frame_count;
  logic [7:0]    dbg_snap;
`endif

  always #5 clk = ~clk;

  scanchain_target dut (
    .clk         (clk),
    .reset       (reset),
    .scan_clk    (scan_clk),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_reset  (scan_reset),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_payload (out_payload),
    .frame_error (frame_error),
    .overrun     (overrun)
`ifdef SCANCHAIN_TARGET_DEBUG_EN
    ,
    .debug_bit_count   (debug_bit_count),
    .debug_frame_count (debug_frame_count)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Monotonic event totals; tests work on differences
  int err_total = 0, ovr_total = 0, vld_total = 0;
  logic [FRAME-1:0] cap_frame = '0;

  always @(negedge clk) begin
    if (frame_error) err_total++;
    if (overrun)     ovr_total++;
    if (out_valid) begin
      vld_total++;
      cap_frame = {out_addr, out_payload};
    end
  end

  // Frame-level reference model
  logic             m_valid;
  logic [FRAME-1:0] m_data;
  int               m_frames;
  int               b_err, b_ovr, b_vld;

  function automatic logic [191:0] rnd_frame();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_bits(input logic [191:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk); scan_in = d[i];
      repeat (3) @(negedge clk); scan_clk = 1'b1;
      repeat (3) @(negedge clk); scan_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [191:0] d, input int n);
    b_err = err_total; b_ovr = ovr_total; b_vld = vld_total;
    @(negedge clk); scan_en = 1'b1;
    repeat (4) @(negedge clk);
    drive_bits(d, n);
    repeat (4) @(negedge clk);
`ifdef SCANCHAIN_TARGET_DEBUG_EN
    dbg_snap = debug_bit_count;
`endif
    scan_en = 1'b0;
    repeat (10) @(negedge clk);
    if (n == int'(FRAME) && !m_valid) begin
      m_data = d[FRAME-1:0];
      m_frames++;
      m_valid = !out_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; scan_clk = 0; scan_en = 0; scan_in = 0; scan_reset = 0; out_ready = 0;
    m_valid = 0; m_data = '0; m_frames = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out_valid, frame_error, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {out_valid, frame_error, overrun});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({out_addr, out_payload} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {out_addr, out_payload});
    end
  endtask

  task automatic test_good_frame();
    logic [191:0] d;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        d = '0;
        d[FRAME-1:0] = {12'hA5C, 160'h0123456789ABCDEF0123456789ABCDEF0123CDEF};
      end else d = rnd_frame();
      run_frame(d, FRAME);
      n_tests++;
      if (vld_total - b_vld !== 1) begin
        n_fail++; $display("FAIL good_vld_cycles[%0d]: got %0d expected 1", k, vld_total - b_vld);
      end
      n_tests++;
      if (cap_frame[FRAME-1 -: AB] !== m_data[FRAME-1 -: AB]) begin
        n_fail++; $display("FAIL good_addr[%0d]: got %h expected %h", k, cap_frame[FRAME-1 -: AB], m_data[FRAME-1 -: AB]);
      end
      n_tests++;
      if (cap_frame[PB-1:0] !== m_data[PB-1:0]) begin
        n_fail++; $display("FAIL good_payload[%0d]: got %h expected %h", k, cap_frame[PB-1:0], m_data[PB-1:0]);
      end
      n_tests++;
      if ((err_total - b_err) + (ovr_total - b_ovr) !== 0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL good_pulses[%0d]: err %0d ovr %0d valid %b expected 0 0 0",
                           k, err_total - b_err, ovr_total - b_ovr, out_valid);
      end
    end
  endtask

  task automatic test_bad_count();
    int lens[4];
    lens[0] = FRAME - 1; lens[1] = FRAME + 1; lens[2] = $urandom_range(1, FRAME - 2); lens[3] = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame(rnd_frame(), lens[k]);
      n_tests++;
      if (err_total - b_err !== 1) begin
        n_fail++; $display("FAIL bad_err_pulse[len %0d]: got %0d pulses expected 1", lens[k], err_total - b_err);
      end
      n_tests++;
      if (vld_total - b_vld !== 0 || ovr_total - b_ovr !== 0) begin
        n_fail++; $display("FAIL bad_no_commit[len %0d]: valid cycles %0d ovr %0d expected 0 0",
                           lens[k], vld_total - b_vld, ovr_total - b_ovr);
      end
      n_tests++;
      if ({out_addr, out_payload} !== m_data) begin
        n_fail++; $display("FAIL bad_held_data[len %0d]: got %h expected %h", lens[k], {out_addr, out_payload}, m_data);
      end
    end
  endtask

  task automatic test_overrun();
    logic [191:0] a, b, c;
    a = rnd_frame(); b = rnd_frame(); c = rnd_frame();
    out_ready = 1'b0;
    run_frame(a, FRAME);
    n_tests++;
    if (out_valid !== 1'b1 || {out_addr, out_payload} !== a[FRAME-1:0]) begin
      n_fail++; $display("FAIL ovr_first_held: valid %b data %h expected 1 %h", out_valid, {out_addr, out_payload}, a[FRAME-1:0]);
    end
    run_frame(b, FRAME);
    n_tests++;
    if (ovr_total - b_ovr !== 1 || err_total - b_err !== 0) begin
      n_fail++; $display("FAIL ovr_pulse: ovr %0d err %0d expected 1 0", ovr_total - b_ovr, err_total - b_err);
    end
    n_tests++;
    if (out_valid !== 1'b1 || {out_addr, out_payload} !== a[FRAME-1:0]) begin
      n_fail++; $display("FAIL ovr_keep_first: valid %b data %h expected 1 %h", out_valid, {out_addr, out_payload}, a[FRAME-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || {out_addr, out_payload} !== a[FRAME-1:0]) begin
      n_fail++; $display("FAIL ovr_pop: valid %b data %h expected 0 %h", out_valid, {out_addr, out_payload}, a[FRAME-1:0]);
    end
    out_ready = 1'b1;
    run_frame(c, FRAME);
    n_tests++;
    if (vld_total - b_vld !== 1 || cap_frame !== c[FRAME-1:0]) begin
      n_fail++; $display("FAIL ovr_next_commit: valid cycles %0d data %h expected 1 %h", vld_total - b_vld, cap_frame, c[FRAME-1:0]);
    end
  endtask

  task automatic test_scan_reset();
    logic [191:0] y;
    y = rnd_frame();
    out_ready = 1'b1;
    b_err = err_total; b_ovr = ovr_total; b_vld = vld_total;
    @(negedge clk); scan_en = 1'b1;
    repeat (4) @(negedge clk);
    drive_bits(rnd_frame(), 80);
    scan_reset = 1'b1;
    repeat (6) @(negedge clk);
    scan_en = 1'b0;
    repeat (6) @(negedge clk);
    scan_reset = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (err_total - b_err !== 0 || ovr_total - b_ovr !== 0 || vld_total - b_vld !== 0) begin
      n_fail++; $display("FAIL sreset_abort: err %0d ovr %0d valid cycles %0d expected 0 0 0",
                         err_total - b_err, ovr_total - b_ovr, vld_total - b_vld);
    end
    run_frame(y, FRAME);
    n_tests++;
    if (vld_total - b_vld !== 1 || cap_frame !== y[FRAME-1:0] || err_total - b_err !== 0) begin
      n_fail++; $display("FAIL sreset_second: valid cycles %0d err %0d data %h expected 1 0 %h",
                         vld_total - b_vld, err_total - b_err, cap_frame, y[FRAME-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [191:0] b;
    b = rnd_frame();
    out_ready = 1'b0;
    run_frame(rnd_frame(), FRAME);
    @(negedge clk); scan_en = 1'b1;
    repeat (4) @(negedge clk);
    drive_bits(rnd_frame(), 100);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, frame_error, overrun, out_addr, out_payload} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: valid %b data %h expected 0 0", out_valid, {out_addr, out_payload});
    end
    scan_en = 1'b0;
    m_valid = 1'b0; m_data = '0; m_frames = 0;
    repeat (3) @(negedge clk);
    b_err = err_total; b_ovr = ovr_total;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (err_total - b_err !== 0 || ovr_total - b_ovr !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release: err %0d ovr %0d valid %b expected 0 0 0",
                         err_total - b_err, ovr_total - b_ovr, out_valid);
    end
    out_ready = 1'b1;
    run_frame(b, FRAME);
    n_tests++;
    if (vld_total - b_vld !== 1 || cap_frame !== b[FRAME-1:0]) begin
      n_fail++; $display("FAIL rst_mid_next: valid cycles %0d data %h expected 1 %h", vld_total - b_vld, cap_frame, b[FRAME-1:0]);
    end
  endtask

`ifdef SCANCHAIN_TARGET_DEBUG_EN
  task automatic test_debug();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) run_frame(rnd_frame(), FRAME);
    n_tests++;
    if (debug_frame_count !== 8'(m_frames)) begin
      n_fail++; $display("FAIL dbg_frame_count: got %0d expected %0d", debug_frame_count, m_frames);
    end
    n_tests++;
    if (dbg_snap !== 8'(FRAME)) begin
      n_fail++; $display("FAIL dbg_bit_count: got %0d expected %0d", dbg_snap, FRAME);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_count();
    test_overrun();
    test_scan_reset();
    test_reset_mid();
`ifdef SCANCHAIN_TARGET_DEBUG_EN
    test_debug();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scanchain_target.md
SCANCHAIN_TARGET -- requirements
Module: scanchain_target

Interface
REQ-001 Parameter ADDR_BITS, default 12, is the address field width in bits.
REQ-002 Parameter PAYLOAD_BITS, default 160, is the payload field width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, is the synchronizer depth per scan input.
REQ-004 clk  in  1  single FPGA clock; all logic SHALL run on its rising edge.
REQ-005 reset  in  1  reset; asynchronous, active-high.
REQ-006 scan_clk  in  1  scan clock from the scan initiator; asynchronous to clk.
REQ-007 scan_en  in  1  frame enable; high for the duration of one frame.
REQ-008 scan_in  in  1  serial scan data.
REQ-009 scan_reset  in  1  scan-side abort/clear, active-high.
REQ-010 out_valid  out  1  committed frame available.
REQ-011 out_ready  in  1  consumer accepts the committed frame.
REQ-012 out_addr  out  ADDR_BITS  committed address.
REQ-013 out_payload  out  PAYLOAD_BITS  committed payload.
REQ-014 frame_error  out  1  one-cycle pulse; a frame ended with the wrong bit count.
REQ-015 overrun  out  1  one-cycle pulse; a good frame was dropped because out_valid was high.

Function
REQ-016 Each scan input SHALL pass through a SYNC_STAGES flop synchronizer before use.
REQ-017 A scan_clk rising edge SHALL be detected from the synchronized value versus its 1-cycle delayed copy.
REQ-018 Shift FSM states: IDLE, SHIFT. IDLE->SHIFT on synced scan_en high. SHIFT->IDLE on synced scan_en low.
REQ-019 In SHIFT, on each detected scan_clk rise, the 172-bit (ADDR_BITS+PAYLOAD_BITS) shift register SHALL shift left, with synced scan_in entering the LSB.
REQ-020 The bit counter SHALL increment on each shift and saturate at FRAME+1, where FRAME = ADDR_BITS+PAYLOAD_BITS.
REQ-021 Field mapping after a frame: upper ADDR_BITS = address, lower PAYLOAD_BITS = payload. The first bit shifted in is the address MSB.
REQ-022 On SHIFT->IDLE with count == FRAME and out_valid low: load out_addr/out_payload and set out_valid in the same cycle, i.e. out_valid high 1 clk after the synced scan_en low is seen.
REQ-023 On SHIFT->IDLE with count != FRAME: pulse frame_error for 1 cycle, discard the frame, and leave the outputs unchanged.
REQ-024 On SHIFT->IDLE with count == FRAME and out_valid high: pulse overrun for 1 cycle and keep the held frame.
REQ-025 out_valid SHALL clear on the cycle after out_valid & out_ready.
REQ-026 out_addr and out_payload SHALL be stable while out_valid is high.
REQ-027 Shifting SHALL continue while out_valid is held; the shift register is independent of the output register.
REQ-028 Entering SHIFT SHALL clear the bit counter.
REQ-029 Synced scan_reset high in any state SHALL:
  - clear the shift register and bit counter;
  - force the FSM to IDLE;
  - suppress frame_error and overrun;
  - not affect out_valid or the held frame.
REQ-030 A scan_clk rise coincident with synced scan_en falling SHALL NOT be shifted.

Reset
REQ-031 Reset SHALL asynchronously clear to zero: FSM (IDLE), shift register, counter, synchronizers, out_valid, out_addr, out_payload, frame_error, overrun.
REQ-032 Reset mid-frame SHALL abort the frame with no error or overrun pulse after release.

Configuration
REQ-033 With SCANCHAIN_TARGET_DEBUG_EN defined, the module SHALL add two outputs:
  - debug_bit_count  out  8  live bit counter;
  - debug_frame_count  out  8  wrapping count of committed frames, reset to 0.
REQ-034 Without SCANCHAIN_TARGET_DEBUG_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 172-bit frame, addr 0xA5C, payload 160'h0123...CDEF, out_ready=1 -> out_valid 1 cycle with matching fields, then 0, no error pulses.
REQ-036 171-bit frame -> frame_error single pulse, out_valid stays 0; a 173-bit frame gives the same result.
REQ-037 Two good frames with out_ready=0 -> first frame held, overrun pulse on second; out_ready=1 -> first frame data, out_valid drops.
REQ-038 scan_reset asserted after 80 bits, then a full 172-bit frame -> only the second frame is committed, no frame_error.
REQ-039 reset asserted mid-frame (bit 100) -> all outputs 0 immediately; next full frame commits correctly.
REQ-040 With SCANCHAIN_TARGET_DEBUG_EN defined -> debug_frame_count=3 after 3 good frames; debug_bit_count=172 before scan_en falls.
